cam_init_sequencer: RTL and testbench
=====================================

Name: cam_init_sequencer

Overview:
- Configuration controller for the OV7670 capture path.
- After power-up, walks a synchronous register table and issues each {register address, value} pair to an external SCCB write engine over a req/done handshake.
- Handles sensor soft-reset settling time and NACK retries.
- Asserts init_done, which drives the capture module's initialisation-complete enable; no frame capture is qualified before init_done is high.

Parameters:
- PWRUP_CYC, 1000000, clk cycles to wait after reset before the first write (20 ms at 50 MHz).
- SRST_CYC, 50000, settle cycles after a soft-reset entry (addr 0x12 with data bit7 = 1).
- GAP_CYC, 500, idle cycles between consecutive SCCB transactions, including retries.
- NUM_REGS, 166, number of table entries; range 1..256.
- MAX_RETRY, 3, NACKed attempts per entry before the sequencer aborts.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle re-initialisation request; honoured only in DONE or ERR.
- tbl_idx  out  8  table read index.
- tbl_data  in  16  table word {addr[15:8], value[7:0]}; valid 1 cycle after tbl_idx changes.
- wr_req  out  1  SCCB write request, held high until wr_done.
- wr_addr  out  8  register address; stable while wr_req = 1.
- wr_data  out  8  register value; stable while wr_req = 1.
- wr_done  in  1  single-cycle pulse: SCCB transaction finished.
- wr_ack_ok  in  1  sampled with wr_done; 1 = all bytes ACKed, 0 = NACK.
- busy  out  1  high in every state except DONE and ERR.
- init_done  out  1  table fully written; feeds the capture enable.
- init_err  out  1  aborted after MAX_RETRY NACKs on a single entry.

Behaviour:
- Reset (asynchronous, any state, including mid-transaction):
  - state = PWRUP; all counters = 0.
  - tbl_idx = 0, wr_req = 0, wr_addr = 0, wr_data = 0.
  - init_done = 0, init_err = 0, busy = 1.
- States: PWRUP, FETCH, LATCH, REQ, WAIT, GAP, SRST, DONE, ERR.
- PWRUP: count PWRUP_CYC cycles, then go to FETCH.
- FETCH: tbl_idx holds the current entry; 1 cycle, then LATCH.
- LATCH: register wr_addr <= tbl_data[15:8] and wr_data <= tbl_data[7:0]; go to REQ.
- REQ: drive wr_req = 1; go to WAIT. wr_req stays high through WAIT.
- WAIT: on wr_done, drop wr_req in the next cycle, then:
  - ACK (wr_ack_ok = 1):
    - clear the retry counter.
    - if the entry is a soft reset (wr_addr = 0x12 and wr_data[7] = 1), go to SRST.
    - else if tbl_idx = NUM_REGS-1, go to DONE.
    - else increment tbl_idx and go to GAP with next = FETCH.
  - NACK (wr_ack_ok = 0):
    - increment the retry counter.
    - if it now equals MAX_RETRY, go to ERR.
    - else go to GAP with next = REQ; wr_addr and wr_data are unchanged and tbl_idx is not re-read.
- SRST: count SRST_CYC cycles, then apply the same last-entry / increment rule as the ACK path, skipping GAP.
- GAP: count GAP_CYC cycles, then go to next.
- DONE: init_done = 1 (level, held), busy = 0.
- ERR: init_err = 1 (level, held), busy = 0, init_done = 0.
- start in DONE or ERR:
  - clear init_done and init_err in the next cycle.
  - tbl_idx = 0, retry counter = 0.
  - go to FETCH; PWRUP is skipped.
- start in any other state is ignored.
- wr_done outside WAIT is ignored. wr_done in the same cycle REQ asserts wr_req is impossible: REQ always lasts exactly 1 cycle.
- Delay counters are wide enough for the largest of PWRUP_CYC, SRST_CYC and GAP_CYC; a value of 0 behaves as 1 cycle.
- tbl_idx never exceeds NUM_REGS-1.
- Minimum handshake latency: FETCH to wr_req = 2 cycles.

Test Plan:
1. Baseline: PWRUP_CYC=10, GAP_CYC=2, NUM_REGS=3, table {0x1140, 0x3A04, 0x1500}, SCCB model ACKs after 5 cycles -> three writes in order, wr_req first rises 12 cycles after rst falls, init_done=1 with busy=0 after the 3rd wr_done, tbl_idx=2.
2. Soft reset: entry 0 = 0x1280, SRST_CYC=20 -> entry 1's wr_req rises no earlier than 20 cycles after entry 0's wr_done; no GAP is inserted.
3. Retry: entry 1 NACKed twice then ACKed, MAX_RETRY=3 -> wr_addr/wr_data identical on all 3 attempts, GAP_CYC idle cycles between each, init_done=1, init_err=0.
4. Abort: entry 0 always NACKed, MAX_RETRY=3 -> exactly 3 wr_req pulses, then init_err=1, init_done=0, busy=0, no further wr_req.
5. Restart: start pulsed in ERR and then again in DONE -> flags clear the next cycle, tbl_idx=0, the first wr_req is 2 cycles later with no PWRUP wait; start pulsed mid-WAIT has no effect.
6. Reset mid-transaction: rst asserted while wr_req=1 -> wr_req=0, tbl_idx=0, init_done=0 immediately, and the sequence restarts with the full PWRUP delay after rst falls.

Source files
------------

// File: rtl/cam_init_sequencer.sv
// OV7670 register-table walker: power-up wait, then one SCCB write per table entry,
// with soft-reset settling, NACK retries and a held done/error status for the capture path.
module cam_init_sequencer #(
   parameter int unsigned PWRUP_CYC = 1000000,
   parameter int unsigned SRST_CYC  = 50000,
   parameter int unsigned GAP_CYC   = 500,
   parameter int unsigned NUM_REGS  = 166,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [7:0]  tbl_idx,
   input  logic [15:0] tbl_data,
   output logic        wr_req,
   output logic [7:0]  wr_addr,
   output logic [7:0]  wr_data,
   input  logic        wr_done,
   input  logic        wr_ack_ok,
   output logic        busy,
   output logic        init_done,
   output logic        init_err
);

   // Handshake: wr_req rises with wr_addr/wr_data already stable and stays high until
   // the cycle wr_done is sampled (in WAIT only); wr_ack_ok is meaningful only with wr_done.

   localparam int unsigned MAX_A   = (PWRUP_CYC > SRST_CYC) ? PWRUP_CYC : SRST_CYC;
   localparam int unsigned MAX_CYC = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
   localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
   localparam int unsigned RTY_W   = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

   // A programmed delay of 0 is treated as a single cycle.
   localparam logic [CNT_W-1:0] PWRUP_END = CNT_W'((PWRUP_CYC == 0) ? 0 : PWRUP_CYC - 1);
   localparam logic [CNT_W-1:0] SRST_END  = CNT_W'((SRST_CYC == 0) ? 0 : SRST_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_END   = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
   localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
   localparam logic [7:0]       LAST_IDX  = 8'(NUM_REGS - 1);

   typedef enum logic [3:0] {
      S_PWRUP = 4'd0,
      S_FETCH = 4'd1,
      S_LATCH = 4'd2,
      S_REQ   = 4'd3,
      S_WAIT  = 4'd4,
      S_GAP   = 4'd5,
      S_SRST  = 4'd6,
      S_DONE  = 4'd7,
      S_ERR   = 4'd8
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RTY_W-1:0] retry_q, retry_d;
   logic [7:0]       tbl_idx_q, tbl_idx_d;
   logic             wr_req_q, wr_req_d;
   logic [7:0]       wr_addr_q, wr_addr_d;
   logic [7:0]       wr_data_q, wr_data_d;
   logic             gap_to_req_q, gap_to_req_d;

   logic             is_srst;
   logic             is_last;

   assign is_srst = (wr_addr_q == 8'h12) && wr_data_q[7];
   assign is_last = (tbl_idx_q == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_PWRUP;
         cnt_q        <= '0;
         retry_q      <= '0;
         tbl_idx_q    <= '0;
         wr_req_q     <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         gap_to_req_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         tbl_idx_q    <= tbl_idx_d;
         wr_req_q     <= wr_req_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         gap_to_req_q <= gap_to_req_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = '0;
      retry_d      = retry_q;
      tbl_idx_d    = tbl_idx_q;
      wr_req_d     = wr_req_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      gap_to_req_d = gap_to_req_q;

      case (state_q)
         S_PWRUP: begin
            if (cnt_q == PWRUP_END) state_d = S_FETCH;
            else                    cnt_d   = cnt_q + CNT_W'(1);
         end
         S_FETCH: state_d = S_LATCH;
         S_LATCH: begin
            wr_addr_d = tbl_data[15:8];
            wr_data_d = tbl_data[7:0];
            wr_req_d  = 1'b1;
            state_d   = S_REQ;
         end
         S_REQ: state_d = S_WAIT;
         S_WAIT: begin
            if (wr_done) begin
               wr_req_d = 1'b0;
               if (wr_ack_ok) begin
                  retry_d = '0;
                  if (is_srst) begin
                     state_d = S_SRST;
                  end else if (is_last) begin
                     state_d = S_DONE;
                  end else begin
                     tbl_idx_d    = tbl_idx_q + 8'd1;
                     gap_to_req_d = 1'b0;
                     state_d      = S_GAP;
                  end
               end else begin
                  retry_d = retry_q + RTY_W'(1);
                  if (retry_d == RTY_MAX) begin
                     state_d = S_ERR;
                  end else begin
                     gap_to_req_d = 1'b1;
                     state_d      = S_GAP;
                  end
               end
            end
         end
         S_SRST: begin
            // Settling replaces the inter-transaction gap after a sensor soft reset.
            if (cnt_q == SRST_END) begin
               if (is_last) begin
                  state_d = S_DONE;
               end else begin
                  tbl_idx_d = tbl_idx_q + 8'd1;
                  state_d   = S_FETCH;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_END) begin
               if (gap_to_req_q) begin
                  wr_req_d = 1'b1;
                  state_d  = S_REQ;
               end else begin
                  state_d = S_FETCH;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE, S_ERR: begin
            if (start) begin
               tbl_idx_d = '0;
               retry_d   = '0;
               state_d   = S_FETCH;
            end
         end
         default: state_d = S_PWRUP;
      endcase
   end

   assign tbl_idx   = tbl_idx_q;
   assign wr_req    = wr_req_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = (state_q != S_DONE) && (state_q != S_ERR);
   assign init_done = (state_q == S_DONE);
   assign init_err  = (state_q == S_ERR);

   a_req_stable: assert property (@(posedge clk) disable iff (rst)
      (wr_req_q && $past(wr_req_q)) |-> ($stable(wr_addr_q) && $stable(wr_data_q)));
   a_idx_range: assert property (@(posedge clk) disable iff (rst) tbl_idx_q <= LAST_IDX);
   a_flags_excl: assert property (@(posedge clk) disable iff (rst) !(init_done && init_err));

endmodule

// File: tb/tb_cam_init_sequencer.sv
// Randomised bench for cam_init_sequencer: a table-level model predicts every SCCB write
// (address, data, latency from its trigger) and the final status; a monitor compares.
module tb_cam_init_sequencer;

  localparam int PWRUP = 10;
  localparam int SRST  = 20;
  localparam int GAP   = 2;
  localparam int NUM   = 4;
  localparam int MAXR  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  tbl_idx;
  logic [15:0] tbl_data = 16'h0;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_done = 1'b0;
  logic        wr_ack_ok = 1'b0;
  logic        busy;
  logic        init_done;
  logic        init_err;

  cam_init_sequencer #(
    .PWRUP_CYC(PWRUP), .SRST_CYC(SRST), .GAP_CYC(GAP), .NUM_REGS(NUM), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .tbl_idx(tbl_idx), .tbl_data(tbl_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .wr_ack_ok(wr_ack_ok),
    .busy(busy), .init_done(init_done), .init_err(init_err)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- shared state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] tbl [256];
  int          nacks [NUM];
  logic [31:0] exp_q [$];   // {addr, data, latency-from-reference}
  logic        resp_q [$];  // ack bit for each predicted attempt
  int          ref_edge = 0;
  bit          exp_abort;
  int          exp_idx;
  bit          drop_pending = 0;
  int          drop_edge = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Registered table ROM: data follows tbl_idx one clock later.
  always @(posedge clk) tbl_data <= tbl[tbl_idx];

  // ---------------- SCCB engine responder ----------------
  int lat = 0;
  bit pend = 0;
  always @(negedge clk) begin
    if (rst) begin
      wr_done = 1'b0;
      wr_ack_ok = 1'b0;
      pend = 0;
    end else if (wr_done) begin
      wr_done = 1'b0;
      wr_ack_ok = 1'b0;
    end else if (wr_req) begin
      if (!pend) begin
        pend = 1;
        lat = $urandom_range(1, 5);
      end else begin
        lat--;
        if (lat == 0) begin
          wr_done = 1'b1;
          wr_ack_ok = (resp_q.size() > 0) ? resp_q.pop_front() : 1'b1;
          ref_edge = cyc + 1;
          drop_edge = cyc + 1;
          drop_pending = 1;
          pend = 0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic       prev_req = 1'b0;
  logic [7:0] hold_addr = 8'h0;
  logic [7:0] hold_data = 8'h0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      prev_req = 1'b0;
      drop_pending = 0;
    end else begin
      if (wr_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wr_req", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(wr_addr), int'(e[31:24]));
          chk("wr_data", int'(wr_data), int'(e[23:16]));
          chk("req_latency", cyc - ref_edge, int'(e[15:0]));
        end
        hold_addr = wr_addr;
        hold_data = wr_data;
      end else if (wr_req) begin
        chk("addr_stable", int'(wr_addr), int'(hold_addr));
        chk("data_stable", int'(wr_data), int'(hold_data));
      end
      if (drop_pending && cyc == drop_edge) begin
        chk("wr_req_drop", int'(wr_req), 0);
        drop_pending = 0;
      end
      prev_req = wr_req;
    end
  end

  // ---------------- reference model ----------------
  // Walks the table: each entry is attempted until ACKed or MAXR NACKs accumulate.
  // Latency of each request is measured from the event that released it.
  task automatic model(input int first_delay);
    int d;
    int a;
    bit acked;
    d = first_delay;
    exp_abort = 0;
    exp_idx = NUM - 1;
    for (int i = 0; i < NUM; i++) begin
      a = 0;
      acked = 0;
      while (!acked) begin
        exp_q.push_back({tbl[i], 16'(d)});
        if (a < nacks[i]) begin
          resp_q.push_back(1'b0);
          a++;
          if (a == MAXR) begin
            exp_abort = 1;
            exp_idx = i;
            return;
          end
          d = GAP;
        end else begin
          resp_q.push_back(1'b1);
          acked = 1;
          d = (tbl[i][15:8] == 8'h12 && tbl[i][7]) ? SRST + 2 : GAP + 2;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_table(input logic [15:0] t0, t1, t2, t3);
    tbl[0] = t0; tbl[1] = t1; tbl[2] = t2; tbl[3] = t3;
    for (int i = 0; i < NUM; i++) nacks[i] = 0;
  endtask

  task automatic random_table();
    logic [7:0] a;
    int r;
    for (int i = 0; i < NUM; i++) begin
      a = 8'($urandom_range(0, 255));
      if (a == 8'h12) a = 8'h13;
      tbl[i] = {a, 8'($urandom_range(0, 255))};
      r = $urandom_range(0, 11);
      nacks[i] = (r < 7) ? 0 : (r < 9) ? 1 : (r < 11) ? 2 : 3;
    end
    if ($urandom_range(0, 2) == 0) tbl[$urandom_range(0, NUM - 1)] = {8'h12, 8'h80 | 8'($urandom_range(0, 127))};
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    ref_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_init_done", int'(init_done), 0);
    chk("restart_init_err", int'(init_err), 0);
    chk("restart_tbl_idx", int'(tbl_idx), 0);
    chk("restart_busy", int'(busy), 1);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!wr_req && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("wait_wr_req_timeout", int'(n < 500), 1);
  endtask

  task automatic finish_scenario(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) $display("FAIL %s: busy never dropped", name);
    chk("busy_timeout", int'(n < 3000), 1);
    repeat (30) @(negedge clk);
    chk("final_busy", int'(busy), 0);
    chk("final_init_done", int'(init_done), int'(!exp_abort));
    chk("final_init_err", int'(init_err), int'(exp_abort));
    chk("final_tbl_idx", int'(tbl_idx), exp_idx);
    chk("exp_q_empty", exp_q.size(), 0);
    resp_q.delete();
  endtask

  task automatic check_reset_state();
    chk("rst_wr_req", int'(wr_req), 0);
    chk("rst_tbl_idx", int'(tbl_idx), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_init_err", int'(init_err), 0);
    chk("rst_busy", int'(busy), 1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    ref_edge = cyc;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) tbl[i] = 16'h0;
    repeat (3) @(negedge clk);
    check_reset_state();

    // Baseline: full power-up wait, three ordinary writes plus one more.
    set_table(16'h1140, 16'h3A04, 16'h1500, 16'h8C00);
    model(PWRUP + 2);
    release_reset();
    finish_scenario("baseline");

    // Soft reset on entry 0: settle time replaces the gap.
    set_table(16'h1280, 16'h3A04, 16'h1500, 16'h6B4A);
    model(2);
    do_start();
    finish_scenario("soft_reset");

    // Retry: entry 1 NACKed twice, plus a start pulse during a transaction (ignored).
    set_table(16'h1140, 16'h3A04, 16'h1500, 16'h8C00);
    nacks[1] = 2;
    model(2);
    do_start();
    wait_req();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_scenario("retry");

    // Abort: entry 0 never ACKed.
    set_table(16'h1140, 16'h3A04, 16'h1500, 16'h8C00);
    nacks[0] = 3;
    model(2);
    do_start();
    finish_scenario("abort");

    // Restart out of ERR.
    set_table(16'h1140, 16'h3A04, 16'h1500, 16'h8C00);
    model(2);
    do_start();
    finish_scenario("restart_from_err");

    for (int k = 0; k < 6; k++) begin
      random_table();
      model(2);
      do_start();
      finish_scenario("random");
    end

    // Reset during an active request, then a full power-up sequence.
    set_table(16'h1140, 16'h3A04, 16'h1500, 16'h8C00);
    model(2);
    do_start();
    wait_req();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_state();
    exp_q.delete();
    resp_q.delete();
    repeat (2) @(negedge clk);
    model(PWRUP + 2);
    release_reset();
    finish_scenario("reset_mid_txn");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
